// File: rtl/store_execution.sv
// STORE_V execution: fetches vector tiles from the buffer controller and writes them
// element by element to DRAM from a latched base address.
module store_execution #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [4:0]                                     opcode,
  input  logic [4:0]                                     src_buffer_id,
  input  logic [9:0]                                     length,
  input  logic [ADDR_WIDTH-1:0]                          addr,
  output logic                                           done,
  output logic                                           busy,
  output logic                                           vec_read_enable,
  output logic [4:0]                                     vec_read_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   vec_read_tile,
  input  logic                                           vec_read_valid,
  output logic                                           mem_we,
  output logic [ADDR_WIDTH-1:0]                          mem_addr,
  output logic [DATA_WIDTH-1:0]                          mem_wdata,
  input  logic                                           mem_ready,
  output logic [2:0]                                     state_dbg
);

  localparam int         IDX_WIDTH  = $clog2(TILE_ELEMS);
  localparam logic [4:0] OP_STORE_V = 5'h03;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_TILE  = 3'd1,
    WAIT_TILE = 3'd2,
    WRITE     = 3'd3,
    COMPLETE  = 3'd4
  } state_t;

  state_t                               state, state_next;
  logic [4:0]                           buffer_id_q;
  logic [9:0]                           len_q;
  logic [9:0]                           elem_count;
  logic [9:0]                           count_inc;
  logic [ADDR_WIDTH-1:0]                base_q;
  logic [IDX_WIDTH-1:0]                 idx;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q;
  logic                                 last_in_tile;

  assign count_inc    = elem_count + 10'd1;
  assign last_in_tile = (idx == IDX_WIDTH'(TILE_ELEMS - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (opcode == OP_STORE_V && length != 10'd0) state_next = REQ_TILE;
          else                                         state_next = COMPLETE;
        end
      end
      REQ_TILE:  state_next = WAIT_TILE;
      WAIT_TILE: if (vec_read_valid) state_next = WRITE;
      WRITE: begin
        // The length check wins, so a partial last tile never triggers another fetch.
        if (mem_ready) begin
          if (count_inc == len_q) state_next = COMPLETE;
          else if (last_in_tile)  state_next = REQ_TILE;
        end
      end
      COMPLETE:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      buffer_id_q <= '0;
      len_q       <= '0;
      base_q      <= '0;
      elem_count  <= '0;
      idx         <= '0;
      tile_q      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            buffer_id_q <= src_buffer_id;
            len_q       <= length;
            base_q      <= addr;
            elem_count  <= '0;
            idx         <= '0;
          end
        end
        WAIT_TILE: begin
          if (vec_read_valid) begin
            tile_q <= vec_read_tile;
            idx    <= '0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            elem_count <= count_inc;
            idx        <= idx + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Write handshake: a beat transfers on a cycle where mem_we && mem_ready; while mem_we is
  // high and mem_ready low, mem_addr/mem_wdata hold because they depend only on registers.
  assign busy               = (state != IDLE);
  assign done               = (state == COMPLETE);
  assign vec_read_enable    = (state == REQ_TILE);
  assign vec_read_buffer_id = buffer_id_q;
  assign mem_we             = (state == WRITE);
  assign mem_addr           = (state == WRITE) ? base_q + ADDR_WIDTH'(elem_count) : '0;
  assign mem_wdata          = (state == WRITE) ? tile_q[idx] : '0;
  assign state_dbg          = state;

endmodule
